wr_contrl_sync: RTL and testbench
=================================

Name: wr_contrl_sync

Overview:
- Write-side pointer controller for the dual-clock FIFO.
- Pairs with the read-side controller and sits in the w_clk domain.
- Synchronizes the read domain's Gray read pointer and owns the binary/Gray write pointer.
- Drives the memory write enable and address, and generates full, almost-full, free-count and sticky-overflow status.

Parameters:
- ADDR_WIDTH, 4: memory address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 2: walmost_full asserts when free slots <= AFULL_THRESH; legal range 1..DEPTH-1.
- SYNC_STAGES, 2: flop stages on the r_ptr crossing; minimum 2.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  asynchronous, active-high reset.
- winc  input  1  write request for this cycle.
- ovf_clr  input  1  clears woverflow.
- r_ptr  input  ADDR_WIDTH+1  Gray read pointer from the read domain (asynchronous to w_clk).
- w_ptr  output  ADDR_WIDTH+1  Gray write pointer, registered, to the read domain.
- waddr  output  ADDR_WIDTH  memory write address.
- wclken  output  1  memory write enable.
- wfull  output  1  FIFO full.
- walmost_full  output  1  free slots <= AFULL_THRESH.
- wfree  output  ADDR_WIDTH+1  free slots, 0..DEPTH.
- woverflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Write accept: wclken = winc & ~wfull (combinational). waddr = bn_ptr[ADDR_WIDTH-1:0].
- Pointer update: bn_next = bn_ptr + wclken, modulo 2**(ADDR_WIDTH+1); wrap 31->0 is natural at ADDR_WIDTH=4.
- Gray pointer: g_next = (bn_next>>1) ^ bn_next, registered into w_ptr. w_ptr changes at most 1 bit per w_clk edge and never glitches.
- Read-pointer sync: r_ptr passes through SYNC_STAGES flops to give rq_ptr. Nothing samples r_ptr except the first stage.
- Full: wfull <= (g_next == {~rq_ptr[MSB:MSB-1], rq_ptr[MSB-2:0]}).
  - Registered, so it asserts on the edge that accepts the DEPTH-th outstanding write.
  - It deasserts SYNC_STAGES+1 edges after r_ptr advances. This lag is pessimistic and allowed; it never overwrites unread data.
- Free count: wfree <= DEPTH - (bn_next - gray2bin(rq_ptr)), computed modulo 2**(ADDR_WIDTH+1).
- Almost full: walmost_full <= (free_next <= AFULL_THRESH). It is consistent with wfree on every cycle; wfull=1 implies walmost_full=1.
- Overflow: woverflow <= (winc & wfull) | (woverflow & ~ovf_clr). Set wins over a simultaneous clear.
- A write attempted while full is dropped: no pointer or memory change.
- Reset (w_rst=1, immediate, no clock needed):
  - bn_ptr=0, w_ptr=0, sync flops=0, wfull=0, walmost_full=0, wfree=DEPTH, woverflow=0.
  - wclken is forced to 0 while w_rst=1.
  - Reset mid-operation discards all write state. Resetting both domains together is the integrator's responsibility.
- Simultaneous winc with a read-pointer advance: the write is accepted based on the current wfull. The free count reflects both events once the sync latency has elapsed.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width.
  - localparam-style helper for DEPTH.
  - shared with the read-side controller.
- Sub-module ptr_sync:
  - SYNC_STAGES-deep, WIDTH-wide flop chain with asynchronous active-high reset to 0.
  - Reused in the read domain for w_ptr.
- Top:
  - pointer/flag logic only; no memory inside.

Test Plan (ADDR_WIDTH=4, AFULL_THRESH=2, SYNC_STAGES=2):
- Reset: w_rst=1 with no clock -> w_ptr=0, wfull=0, wfree=16, walmost_full=0, woverflow=0, wclken=0.
- Fill with r_ptr=0, 16 cycles of winc:
  - waddr steps 0..15 with wclken=1 each cycle.
  - walmost_full=1 after the 14th write (wfree=2).
  - wfull=1 and wfree=0 after the 16th; w_ptr=5'b11000.
- Overflow:
  - From full, winc=1 for 1 cycle -> wclken=0, w_ptr unchanged, woverflow=1 next edge.
  - ovf_clr alone -> 0.
  - winc (while full) and ovf_clr in the same cycle -> stays 1.
- Release:
  - From full, r_ptr 00000->00001 -> wfull=0 and wfree=1 exactly 3 w_clk edges later.
  - A winc on that edge is accepted; wfull=1 again on the next edge.
- Wrap: 40 writes while r_ptr tracks w_ptr with 4-cycle lag -> bn_ptr wraps 31->0, every w_ptr change is a 1-bit Gray step, wfull never asserts.
- Async reset mid-fill: after 5 writes, assert w_rst between clock edges -> all outputs return to reset values before the next edge; writes resume from waddr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers (write and read side).
// Gray/binary conversions operate on zero-extended values up to 32 bits wide.
package fifo_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits leave the prefix XOR unchanged, so any narrower width works.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/wr_contrl_sync_ptr_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing into this clock domain.
// Used on r_ptr here and on w_ptr in the read-side controller.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wr_contrl_sync.sv
// Write-side pointer controller of the dual-clock FIFO: owns the write pointer,
// synchronizes the read pointer and produces full / almost-full / free / overflow.
module wr_contrl_sync
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   r_ptr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wclken,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wfree,
    output logic                  woverflow
);

    localparam int            PW      = ADDR_WIDTH + 1;
    localparam int            DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    logic [PW-1:0] bn_ptr;
    logic [PW-1:0] bn_next;
    logic [PW-1:0] g_next;
    logic [PW-1:0] rq_ptr;
    logic [PW-1:0] rq_bin;
    logic [PW-1:0] used_next;
    logic [PW-1:0] free_next;
    logic          full_next;

    ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rsync (
        .clk (w_clk),
        .rst (w_rst),
        .d   (r_ptr),
        .q   (rq_ptr)
    );

    assign wclken = winc & ~wfull & ~w_rst;
    assign waddr  = bn_ptr[ADDR_WIDTH-1:0];

    assign bn_next = bn_ptr + PW'(wclken);
    assign g_next  = PW'(bin2gray(32'(bn_next)));
    assign rq_bin  = PW'(gray2bin(32'(rq_ptr)));

    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    assign full_next = (g_next == {~rq_ptr[PW-1:PW-2], rq_ptr[PW-3:0]});
    assign used_next = bn_next - rq_bin;
    assign free_next = DEPTH_P - used_next;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            bn_ptr       <= '0;
            w_ptr        <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wfree        <= DEPTH_P;
            woverflow    <= 1'b0;
        end else begin
            bn_ptr       <= bn_next;
            w_ptr        <= g_next;
            wfull        <= full_next;
            wfree        <= free_next;
            walmost_full <= (free_next <= AFULL_P);
            woverflow    <= (winc & wfull) | (woverflow & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_wr_contrl_sync.sv
// Scoreboard bench for wr_contrl_sync: an occupancy-count model predicts each cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_wr_contrl_sync;

    logic       w_clk = 1'b0;
    logic       w_rst = 1'b0;
    logic       winc = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [4:0] r_ptr = '0;
    logic [4:0] w_ptr;
    logic [3:0] waddr;
    logic       wclken;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wfree;
    logic       woverflow;
    bit         clk_en = 1'b0;

    wr_contrl_sync #(.ADDR_WIDTH(4), .AFULL_THRESH(2), .SYNC_STAGES(2)) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .winc         (winc),
        .ovf_clr      (ovf_clr),
        .r_ptr        (r_ptr),
        .w_ptr        (w_ptr),
        .waddr        (waddr),
        .wclken       (wclken),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wfree        (wfree),
        .woverflow    (woverflow)
    );

    always #5 if (clk_en) w_clk = ~w_clk;

    typedef struct {
        bit       acc;
        bit [3:0] waddr;
        bit [4:0] wptr;
        bit       full;
        bit       af;
        bit [4:0] free;
        bit       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: total writes accepted / reads done as plain counts, read value seen
    // by the write side is the one driven two cycles before the sampling edge.
    int   wtot, rtot;
    int   rhist[$];
    bit   m_full, m_af, m_ovf;
    int   m_free;
    logic [4:0] prev_wptr = '0;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wtot = 0; rtot = 0;
        rhist = '{0, 0};
        m_full = 0; m_af = 0; m_ovf = 0; m_free = 16;
    endtask

    task automatic cyc(input bit wi, input bit oc, input bit radv);
        exp_t e;
        int   rs, used;
        bit   acc;
        @(posedge w_clk); #1;
        if (radv && rtot < wtot) rtot++;
        winc = wi; ovf_clr = oc; r_ptr = gray(rtot);
        acc = wi && !m_full;
        e.acc = acc; e.waddr = 4'(wtot % 16); e.wptr = gray(wtot);
        e.full = m_full; e.af = m_af; e.free = 5'(m_free); e.ovf = m_ovf;
        exp_q.push_back(e);
        rs = rhist.pop_front();
        rhist.push_back(rtot);
        m_ovf = (wi && m_full) || (m_ovf && !oc);
        if (acc) wtot++;
        used = wtot - rs;
        m_full = (used == 16);
        m_free = 16 - used;
        m_af = (m_free <= 2);
    endtask

    task automatic async_reset();
        @(negedge w_clk); #2;
        w_rst = 1'b1;
        #1;
        chk("rst_wptr", w_ptr, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_wfree", wfree, 16);
        chk("rst_waf", walmost_full, 0);
        chk("rst_wovf", woverflow, 0);
        chk("rst_wclken", wclken, 0);
        winc = 0; ovf_clr = 0; r_ptr = '0;
        prev_wptr = '0;
        model_reset();
        #1 w_rst = 1'b0;
    endtask

    always @(negedge w_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wclken", wclken, e.acc);
            chk("waddr", waddr, e.waddr);
            chk("w_ptr", w_ptr, e.wptr);
            chk("wfull", wfull, e.full);
            chk("walmost_full", walmost_full, e.af);
            chk("wfree", wfree, e.free);
            chk("woverflow", woverflow, e.ovf);
            if (w_ptr != prev_wptr)
                chk("gray_step_bits", $countones(w_ptr ^ prev_wptr), 1);
            prev_wptr = w_ptr;
        end
    end

    initial begin
        #1 w_rst = 1'b1;
        winc = 1'b1;
        #2;
        chk("init_wptr", w_ptr, 0);
        chk("init_wfull", wfull, 0);
        chk("init_wfree", wfree, 16);
        chk("init_waf", walmost_full, 0);
        chk("init_wovf", woverflow, 0);
        chk("init_wclken", wclken, 0);
        winc = 1'b0;
        model_reset();
        #1 w_rst = 1'b0;
        clk_en = 1'b1;

        // fill with no reads
        for (int i = 0; i < 16; i++) cyc(1, 0, 0);
        // overflow handling
        cyc(1, 0, 0);
        chk("full_wptr", w_ptr, 5'b11000);
        chk("full_wfree", wfree, 0);
        chk("full_wfull", wfull, 1);
        chk("full_wclken", wclken, 0);
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        // release one slot, write on the edge wfull drops
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        // drain
        for (int i = 0; i < 24; i++) cyc(0, 0, 1);
        // wrap with reader trailing by four
        for (int i = 0; i < 40; i++) cyc(1, 0, (wtot - rtot) >= 4);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1);
        // async reset mid-fill
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        async_reset();
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        // randomized traffic
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        @(negedge w_clk); #1;
        if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
